// File: rtl/reg_pkg.sv
// -----------------------------------------------------------------------------
// reg_pkg
// Shared constants and writeback FSM state type for the register-file
// write path.
//   RF_ADDR_W / RF_DATA_W / RF_NREGS : register file geometry
//   WB_NREQ                          : default number of writeback requesters
//   wb_state_e                       : writeback stage state
// -----------------------------------------------------------------------------
package reg_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;
    localparam int RF_NREGS  = 32;
    localparam int WB_NREQ   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,   // stage empty
        ISSUE = 2'b01,   // stage full, commit attempted this cycle
        HOLD  = 2'b10    // stage full, previous commit blocked by stall
    } wb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin grant. Searches upward from i_rr_ptr+1 (mod NREQ)
// and grants the first valid requester.
//   i_req_valid  : per-requester request
//   i_rr_ptr     : index of the last granted requester
//   i_enable     : 0 forces no grant
//   o_grant      : one-hot grant (all zero when nothing granted)
//   o_grant_idx  : index of the granted requester (0 when nothing granted)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NREQ  = 3,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  i_req_valid,
    input  logic [PTR_W-1:0] i_rr_ptr,
    input  logic             i_enable,
    output logic [NREQ-1:0]  o_grant,
    output logic [PTR_W-1:0] o_grant_idx
);

    logic             w_found;
    logic [PTR_W-1:0] w_idx;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_idx       = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            w_idx = PTR_W'((32'(i_rr_ptr) + k) % NREQ);
            if (i_enable && !w_found && i_req_valid[w_idx]) begin
                w_found        = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = w_idx;
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// -----------------------------------------------------------------------------
// reg_write_arbiter
// Shares the single register-file write port among NREQ writeback requesters.
// Round-robin grant, one write per cycle, buffered in one writeback stage and
// decoded to one-hot WriteEn lines.
//   clk, reset  : rising-edge clock, asynchronous active-low reset
//   req_valid   : requester i has a write pending
//   req_addr    : destination of requester i, slice [i*ADDR_W +: ADDR_W]
//   req_data    : data of requester i, slice [i*DATA_W +: DATA_W]
//   req_ready   : one-hot grant; transfer when valid & ready
//   stall       : blocks grants and commit
//   wr_en       : one-hot WriteEn to the register array
//   wr_data     : data to all register inputs
//   pend_valid  : writeback stage holds an uncommitted write
//   pend_addr   : destination of that write
// -----------------------------------------------------------------------------
module reg_write_arbiter
    import reg_pkg::*;
#(
    parameter int NREQ   = WB_NREQ,
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int NREGS  = RF_NREGS
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        req_ready,
    input  logic                   stall,
    output logic [NREGS-1:0]       wr_en,
    output logic [DATA_W-1:0]      wr_data,
    output logic                   pend_valid,
    output logic [ADDR_W-1:0]      pend_addr
);

    localparam int PTR_W = $clog2(NREQ);

    wb_state_e         r_state;
    logic [PTR_W-1:0]  r_rr_ptr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;

    logic              w_arb_en;
    logic [NREQ-1:0]   w_grant;
    logic [PTR_W-1:0]  w_grant_idx;
    logic              w_xfer;
    logic              w_commit;

    // Reset is folded in so no grant is shown while the flops are held clear.
    assign w_arb_en = reset & ~stall;

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .i_req_valid (req_valid),
        .i_rr_ptr    (r_rr_ptr),
        .i_enable    (w_arb_en),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    assign req_ready = w_grant;
    assign w_xfer    = |w_grant;

    // Commit depends on the current-cycle stall, so wr_en is decoded from the
    // stage registers rather than held in its own flop.
    assign w_commit = reset & ~stall & (r_state != IDLE);

    // $zero is never written, but the stage is still consumed.
    assign wr_en = (w_commit && r_addr != '0) ? (NREGS'(1) << r_addr) : '0;

    assign wr_data    = r_data;
    assign pend_valid = (r_state != IDLE);
    assign pend_addr  = r_addr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_rr_ptr <= PTR_W'(NREQ - 1);
            r_addr   <= '0;
            r_data   <= '0;
        end else if (w_xfer) begin
            // A grant only happens with stall=0, so any held write commits
            // in the same cycle and the stage can be refilled.
            r_addr   <= req_addr[w_grant_idx*ADDR_W +: ADDR_W];
            r_data   <= req_data[w_grant_idx*DATA_W +: DATA_W];
            r_rr_ptr <= w_grant_idx;
            r_state  <= ISSUE;
        end else if (r_state != IDLE && stall) begin
            r_state <= HOLD;
        end else begin
            r_state <= IDLE;
        end
    end

endmodule
